// File: rtl/display_pkg.sv
// Shared types, constants and the hex-to-segment decoder for the memory display controller.
package display_pkg;

   typedef enum logic [1:0] {
      MODE_MEM  = 2'd0,
      MODE_INST = 2'd1,
      MODE_AUTO = 2'd2
   } mode_e;

   // Active-low segments: all off.
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      seg = SEG_BLANK;
      unique case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-FF synchroniser -> stable-count debounce -> one-cycle rising-edge pulse.
module button_debouncer #(
   parameter int unsigned CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic press_o
);

   localparam int unsigned CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            press_q, press_d;

   // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CntMax) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      press_d = level_d & ~level_q;
   end

   // Synchroniser and debounce state.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/memory_display_controller.sv
// Debug viewer: steps a data-memory inspect address with buttons and shows memory contents or the
// current instruction in hex on a 4-digit multiplexed seven-segment display.
module memory_display_controller
   import display_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned REFRESH_DIV     = 100_000,
   parameter int unsigned AUTO_STEP_DIV   = 100_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_next,
   input  logic        btn_prev,
   input  logic        btn_mode,
   input  logic [15:0] curr_inst,
   input  logic [7:0]  data_on_dm,
   output logic [3:0]  addr_on_dm,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an
);

   localparam int unsigned RefW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned StepW = (AUTO_STEP_DIV > 1) ? $clog2(AUTO_STEP_DIV) : 1;
   localparam logic [RefW-1:0]  RefMax  = RefW'(REFRESH_DIV - 1);
   localparam logic [StepW-1:0] StepMax = StepW'(AUTO_STEP_DIV - 1);

   logic next_press, prev_press, mode_press;

   button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
      .clk(clk), .reset(reset), .btn_i(btn_next), .press_o(next_press)
   );
   button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_prev (
      .clk(clk), .reset(reset), .btn_i(btn_prev), .press_o(prev_press)
   );
   button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
      .clk(clk), .reset(reset), .btn_i(btn_mode), .press_o(mode_press)
   );

   mode_e             mode_q, mode_d;
   logic [3:0]        addr_q, addr_d;
   logic [StepW-1:0]  step_cnt_q, step_cnt_d;
   logic              step_tick;
   logic [RefW-1:0]   ref_cnt_q, ref_cnt_d;
   logic [1:0]        digit_sel_q, digit_sel_d;
   logic [7:0]        disp_data_q;
   logic [15:0]       disp_inst_q;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;
   logic [3:0]        an_q, an_d;
   logic [3:0]        nibble;
   logic              blank;

   // Mode FSM, auto-step counter and inspect address; a mode press pre-empts any address change.
   always_comb begin
      mode_d     = mode_q;
      addr_d     = addr_q;
      step_cnt_d = step_cnt_q;
      step_tick  = 1'b0;
      if (mode_q == MODE_AUTO) begin
         if (step_cnt_q == StepMax) begin
            step_cnt_d = '0;
            step_tick  = 1'b1;
         end else begin
            step_cnt_d = step_cnt_q + 1'b1;
         end
      end
      if (mode_press) begin
         step_cnt_d = '0;
         unique case (mode_q)
            MODE_MEM:  mode_d = MODE_INST;
            MODE_INST: mode_d = MODE_AUTO;
            default:   mode_d = MODE_MEM;
         endcase
      end else begin
         unique case (mode_q)
            MODE_MEM: begin
               if (next_press && !prev_press) begin
                  addr_d = addr_q + 4'd1;
               end else if (prev_press && !next_press) begin
                  addr_d = addr_q - 4'd1;
               end
            end
            MODE_AUTO: begin
               if (step_tick) begin
                  addr_d = addr_q + 4'd1;
               end
            end
            default: addr_d = addr_q;
         endcase
      end
   end

   // Refresh divider and digit select.
   always_comb begin
      ref_cnt_d   = ref_cnt_q + 1'b1;
      digit_sel_d = digit_sel_q;
      if (ref_cnt_q == RefMax) begin
         ref_cnt_d   = '0;
         digit_sel_d = digit_sel_q + 2'd1;
      end
   end

   // Digit content for the currently selected position.
   always_comb begin
      nibble = 4'h0;
      blank  = 1'b0;
      dp_d   = 1'b1;
      if (mode_q == MODE_INST) begin
         nibble = disp_inst_q[{digit_sel_q, 2'b00} +: 4];
      end else begin
         case (digit_sel_q)
            2'd3: nibble = addr_q;
            2'd2: blank  = 1'b1;
            2'd1: nibble = disp_data_q[7:4];
            default: nibble = disp_data_q[3:0];
         endcase
         if (mode_q == MODE_AUTO && digit_sel_q == 2'd3) begin
            dp_d = 1'b0;
         end
      end
      seg_d = blank ? SEG_BLANK : hex_to_seg(nibble);
      an_d  = blank ? 4'hF : ~(4'b0001 << digit_sel_q);
   end

   // All state, including registered display outputs and captured processor values.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q      <= MODE_MEM;
         addr_q      <= 4'h0;
         step_cnt_q  <= '0;
         ref_cnt_q   <= '0;
         digit_sel_q <= 2'd0;
         disp_data_q <= 8'h00;
         disp_inst_q <= 16'h0000;
         seg_q       <= SEG_BLANK;
         dp_q        <= 1'b1;
         an_q        <= 4'hF;
      end else begin
         mode_q      <= mode_d;
         addr_q      <= addr_d;
         step_cnt_q  <= step_cnt_d;
         ref_cnt_q   <= ref_cnt_d;
         digit_sel_q <= digit_sel_d;
         disp_data_q <= data_on_dm;
         disp_inst_q <= curr_inst;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         an_q        <= an_d;
      end
   end

   assign addr_on_dm = addr_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;

endmodule

// File: tb/tb_memory_display_controller.sv
// Self-checking bench for memory_display_controller with a behavioural display/address model.
module tb_memory_display_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        btn_next = 1'b0;
   logic        btn_prev = 1'b0;
   logic        btn_mode = 1'b0;
   logic [15:0] curr_inst = 16'h0000;
   logic [7:0]  data_on_dm;
   logic [3:0]  addr_on_dm;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;

   logic [7:0]  mem [16];
   int          total = 0;
   int          bad = 0;
   logic [3:0]  m_addr;
   int          m_mode;        // 0 memory view, 1 instruction view, 2 auto-scan
   int          cyc = 0;
   bit          auto_mon = 1'b0;
   bit          dp_mon = 1'b0;
   int          last_chg;
   int          n_chg;
   int          n_wrap;

   memory_display_controller #(
      .DEBOUNCE_CYCLES(4),
      .REFRESH_DIV(2),
      .AUTO_STEP_DIV(8)
   ) dut (
      .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev), .btn_mode(btn_mode),
      .curr_inst(curr_inst), .data_on_dm(data_on_dm), .addr_on_dm(addr_on_dm),
      .seg(seg), .dp(dp), .an(an)
   );

   always #5 clk = ~clk;

   assign data_on_dm = mem[addr_on_dm];

   function automatic logic [6:0] ref_hex(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[n];
   endfunction

   function automatic logic [6:0] exp_seg(input int k);
      logic [7:0] d;
      d = mem[m_addr];
      if (m_mode == 1) return ref_hex(curr_inst[4*k +: 4]);
      case (k)
         3: return ref_hex(m_addr);
         1: return ref_hex(d[7:4]);
         0: return ref_hex(d[3:0]);
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic exp_dp(input int k);
      return (m_mode == 2 && k == 3) ? 1'b0 : 1'b1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   // One clock; outputs are sampled on the falling edge.
   task automatic step();
      logic [3:0] nxt;
      @(negedge clk);
      cyc++;
      if (auto_mon && addr_on_dm !== m_addr) begin
         nxt = m_addr + 4'd1;
         check("auto_inc", addr_on_dm, nxt);
         if (last_chg >= 0) check("auto_gap", cyc - last_chg, 8);
         last_chg = cyc;
         m_addr   = nxt;
         n_chg++;
         if (m_addr == 4'd0) n_wrap++;
      end
      if (dp_mon) check("auto_dp", dp, (an == 4'h7) ? 1'b0 : 1'b1);
   endtask

   // which = {mode, prev, next}: hold 10 clk, release 10 clk.
   task automatic press(input logic [2:0] which);
      btn_next = which[0];
      btn_prev = which[1];
      btn_mode = which[2];
      repeat (10) step();
      btn_next = 1'b0;
      btn_prev = 1'b0;
      btn_mode = 1'b0;
      repeat (10) step();
   endtask

   task automatic scan_check(input string tag);
      logic [3:0] seen;
      int k;
      seen = 4'h0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (an === 4'hF) begin
            check({tag, "_blank_seg"}, seg, 7'h7F);
            check({tag, "_blank_dp"}, dp, 1'b1);
         end else begin
            check({tag, "_an_onehot"}, $countones(~an), 1);
            k = 0;
            for (int j = 0; j < 4; j++) if (an[j] === 1'b0) k = j;
            seen[k] = 1'b1;
            check({tag, "_seg"}, seg, exp_seg(k));
            check({tag, "_dp"}, dp, exp_dp(k));
         end
      end
      check({tag, "_digits_seen"}, seen, (m_mode == 1) ? 4'b1111 : 4'b1011);
   endtask

   initial begin
      logic [3:0] exp_an [10];
      int r;
      exp_an = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hF, 4'hF, 4'h7, 4'h7, 4'hE, 4'hE};
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);

      // Reset and refresh order.
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_addr", addr_on_dm, 4'h0);
      check("rst_an", an, 4'hF);
      check("rst_seg", seg, 7'h7F);
      check("rst_dp", dp, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step();
         check("refresh_an", an, exp_an[i]);
      end
      m_addr = 4'h0;
      m_mode = 0;

      // Step and wrap.
      press(3'b001);
      m_addr = m_addr + 4'd1;
      check("next_once", addr_on_dm, m_addr);
      for (int i = 0; i < 15; i++) begin
         press(3'b001);
         m_addr = m_addr + 4'd1;
         check("next_wrap", addr_on_dm, m_addr);
      end
      press(3'b010);
      m_addr = m_addr - 4'd1;
      check("prev_wrap", addr_on_dm, m_addr);
      press(3'b011);
      check("next_prev_same", addr_on_dm, m_addr);

      // Glitch rejection.
      btn_next = 1'b1;
      repeat (2) step();
      btn_next = 1'b0;
      repeat (12) step();
      check("glitch", addr_on_dm, m_addr);
      btn_next = 1'b1;
      repeat (10) step();
      btn_next = 1'b0;
      step();
      btn_next = 1'b1;
      repeat (10) step();
      btn_next = 1'b0;
      repeat (10) step();
      m_addr = m_addr + 4'd1;
      check("dip_single", addr_on_dm, m_addr);

      // Digit content at addr 3 with A5.
      mem[3] = 8'hA5;
      while (m_addr != 4'd3) begin
         press(3'b001);
         m_addr = m_addr + 4'd1;
      end
      check("goto3", addr_on_dm, 4'd3);
      scan_check("mem_a5");

      // Random memory-view stepping.
      for (int i = 0; i < 6; i++) begin
         r = int'($urandom_range(0, 2));
         if (r == 0) begin
            press(3'b001);
            m_addr = m_addr + 4'd1;
         end else if (r == 1) begin
            press(3'b010);
            m_addr = m_addr - 4'd1;
         end else begin
            press(3'b011);
         end
         check("rand_addr", addr_on_dm, m_addr);
         scan_check("mem_rand");
      end

      // Instruction view.
      curr_inst = 16'h1F3A;
      press(3'b100);
      m_mode = 1;
      scan_check("inst_1f3a");
      curr_inst = 16'($urandom);
      repeat (3) step();
      scan_check("inst_rand");
      press(3'b001);
      check("inst_hold", addr_on_dm, m_addr);

      // Auto-scan: steady 8-clk stepping, next/prev ignored.
      auto_mon = 1'b1;
      last_chg = -1;
      n_chg = 0;
      n_wrap = 0;
      press(3'b100);
      m_mode = 2;
      dp_mon = 1'b1;
      for (int i = 0; i < 136; i++) begin
         btn_next = (i >= 20 && i < 40);
         btn_prev = (i >= 60 && i < 72);
         step();
      end
      btn_next = 1'b0;
      btn_prev = 1'b0;
      check("auto_steps", (n_chg >= 16) ? 1 : 0, 1);
      check("auto_wrapped", (n_wrap >= 1) ? 1 : 0, 1);
      dp_mon = 1'b0;
      press(3'b100);
      auto_mon = 1'b0;
      m_mode = 0;
      repeat (30) step();
      check("mem_hold", addr_on_dm, m_addr);
      scan_check("mem_after_auto");

      // Reset while in auto-scan.
      press(3'b100);
      press(3'b100);
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst2_addr", addr_on_dm, 4'h0);
      check("rst2_an", an, 4'hF);
      check("rst2_seg", seg, 7'h7F);
      check("rst2_dp", dp, 1'b1);
      m_addr = 4'h0;
      m_mode = 0;
      repeat (3) step();
      scan_check("post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
